// File: rtl/tart_vis_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tart_vis_fetcher
// Brief    : Visibilities prefetcher. After each correlator bank swap it copies
//            COUNT blocks x BSIZE words over a Wishbone B4 classic master port
//            into a local SRAM. Supports pending-bank counting, overwrite mode,
//            retry/error handling and an XOR or additive checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tart_vis_fetcher #(
   parameter int COUNT  = 24,
   parameter int CBITS  = 5,
   parameter int BSIZE  = 24,
   parameter int BBITS  = 5,
   parameter int WIDTH  = 32,
   parameter int PBITS  = 3,
   parameter int CSUM   = 0,
   parameter int MAXRTY = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   cyc_o,
   output logic                   stb_o,
   output logic                   we_o,
   input  logic                   ack_i,
   input  logic                   wat_i,
   input  logic                   rty_i,
   input  logic                   err_i,
   output logic [CBITS+BBITS-1:0] adr_o,
   output logic [WIDTH/8-1:0]     sel_o,
   input  logic [WIDTH-1:0]       dat_i,
   output logic                   sram_ce_o,
   output logic                   sram_we_o,
   output logic [CBITS+BBITS-1:0] sram_ad_o,
   output logic [WIDTH/8-1:0]     sram_be_o,
   output logic [WIDTH-1:0]       sram_di_o,
   input  logic                   switch_i,
   input  logic                   streamed_i,
   input  logic                   overwrite_i,
   output logic                   available_o,
   output logic [PBITS-1:0]       pending_o,
   output logic [WIDTH-1:0]       checksum_o,
   output logic                   overflow_o,
   output logic                   error_o
);

   localparam int BYTES = WIDTH / 8;
   localparam int RBITS = $clog2(MAXRTY + 2);
   localparam logic [PBITS-1:0] c_PMAX  = '1;
   localparam logic [BBITS-1:0] c_WLAST = BBITS'(BSIZE - 1);
   localparam logic [CBITS-1:0] c_BLAST = CBITS'(COUNT - 1);
   localparam logic [RBITS-1:0] c_RMAX  = RBITS'(MAXRTY);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_STORE = 3'd2,
      ST_READY = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CBITS-1:0]   r_blk;
   logic [BBITS-1:0]   r_word;
   logic [WIDTH-1:0]   r_data;
   logic [WIDTH-1:0]   r_csum;
   logic [WIDTH-1:0]   w_csum_nxt;
   logic [PBITS-1:0]   r_pend;
   logic [RBITS-1:0]   r_rty;
   logic               r_empty;
   logic               r_ovf;
   logic               r_err;
   logic               w_start;
   logic               w_last;
   logic               w_fetch;
   logic               w_store;

   // A new window may begin from IDLE when the SRAM is free (or may be
   // overwritten), or straight out of READY when overwrite is allowed.
   assign w_start = (r_pend != '0) &&
                    (((r_state == ST_IDLE) && (r_empty || overwrite_i)) ||
                     ((r_state == ST_READY) && overwrite_i));
   assign w_last  = (r_blk == c_BLAST) && (r_word == c_WLAST);

   generate
      if (CSUM != 0) begin : g_csum_add
         assign w_csum_nxt = r_csum + r_data;
      end else begin : g_csum_xor
         assign w_csum_nxt = r_csum ^ r_data;
      end
   endgenerate

   // State register; reset drops straight back to IDLE, even mid-transfer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode and bus/SRAM strobes. While the slave signals wait
   // no termination is taken and the strobe simply stays up.
   always_comb begin
      w_next      = r_state;
      w_fetch     = 1'b0;
      w_store     = 1'b0;
      available_o = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            w_fetch = 1'b1;
            if (!wat_i) begin
               if (ack_i)           w_next = ST_STORE;
               else if (rty_i) begin
                  if (r_rty == c_RMAX) w_next = ST_ERROR;
               end
               else if (err_i)      w_next = ST_ERROR;
            end
         end
         ST_STORE: begin
            w_store = 1'b1;
            w_next  = w_last ? ST_READY : ST_FETCH;
         end
         ST_READY: begin
            available_o = 1'b1;
            if (w_start)         w_next = ST_FETCH;
            else if (streamed_i) w_next = ST_IDLE;
         end
         ST_ERROR: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   assign cyc_o      = w_fetch;
   assign stb_o      = w_fetch;
   assign we_o       = 1'b0;
   assign sel_o      = {BYTES{w_fetch}};
   assign adr_o      = {r_blk, r_word};
   assign sram_ce_o  = w_store;
   assign sram_we_o  = w_store;
   assign sram_be_o  = {BYTES{w_store}};
   assign sram_ad_o  = {r_blk, r_word};
   assign sram_di_o  = r_data;
   assign pending_o  = r_pend;
   assign checksum_o = r_csum;
   assign overflow_o = r_ovf;
   assign error_o    = r_err;

   // Pending-bank counter: a swap and a start together cancel; saturates with a sticky overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else if (switch_i && !w_start) begin
         if (r_pend == c_PMAX) r_ovf  <= 1'b1;
         else                  r_pend <= r_pend + 1'b1;
      end else if (!switch_i && w_start) begin
         r_pend <= r_pend - 1'b1;
      end
   end

   // SRAM window occupancy: cleared by a start, set once the window is read out or discarded.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                     r_empty <= 1'b1;
      else if (w_start)              r_empty <= 1'b0;
      else if (r_state == ST_ERROR)  r_empty <= 1'b1;
      else if (streamed_i)           r_empty <= 1'b1;
   end

   // Transfer datapath: address walk, word latch, checksum, retry count and sticky error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_blk  <= '0;
         r_word <= '0;
         r_data <= '0;
         r_csum <= '0;
         r_rty  <= '0;
         r_err  <= 1'b0;
      end else if (w_start) begin
         r_blk  <= '0;
         r_word <= '0;
         r_csum <= '0;
         r_rty  <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (!wat_i) begin
                  if (ack_i)      r_data <= dat_i;
                  else if (rty_i) r_rty  <= r_rty + 1'b1;
               end
            end
            ST_STORE: begin
               r_csum <= w_csum_nxt;
               r_rty  <= '0;
               if (r_word == c_WLAST) begin
                  r_word <= '0;
                  r_blk  <= r_blk + 1'b1;
               end else begin
                  r_word <= r_word + 1'b1;
               end
            end
            ST_ERROR: r_err <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tart_vis_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tart_vis_fetcher
// Brief    : Scoreboard bench for tart_vis_fetcher. A Wishbone slave model
//            answers the fetcher; expected SRAM writes are queued by the
//            stimulus and popped by a monitor. Two instances share all inputs:
//            one XOR checksum, one additive checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tart_vis_fetcher;

   localparam int NW = 576;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack = 1'b0, wat = 1'b0, rty = 1'b0, err = 1'b0;
   logic [31:0] dat = '0;
   logic        sw = 1'b0, strm = 1'b0, ovw = 1'b0;

   logic        cyc, stb, we, sce, swe, avail, ovf, errf;
   logic [9:0]  adr, sad;
   logic [3:0]  sel, sbe;
   logic [31:0] sdi, csum;
   logic [2:0]  pend;

   logic        s_cyc, s_stb, s_we, s_sce, s_swe, s_avail, s_ovf, s_errf;
   logic [9:0]  s_adr, s_sad;
   logic [3:0]  s_sel, s_sbe;
   logic [31:0] s_sdi, s_csum;
   logic [2:0]  s_pend;

   int          errors = 0;
   int          checks = 0;
   logic [41:0] q[$];
   int          mode = 0;
   logic        inj = 1'b0;
   logic [9:0]  inj_adr = '0;
   int          rty_n = 0, rty_done = 0, wat_n = 0, wat_done = 0;

   always #5 clk = ~clk;

   tart_vis_fetcher #(.CSUM(0)) dut (
      .clk_i(clk), .rst_i(rst), .cyc_o(cyc), .stb_o(stb), .we_o(we),
      .ack_i(ack), .wat_i(wat), .rty_i(rty), .err_i(err), .adr_o(adr), .sel_o(sel),
      .dat_i(dat), .sram_ce_o(sce), .sram_we_o(swe), .sram_ad_o(sad), .sram_be_o(sbe),
      .sram_di_o(sdi), .switch_i(sw), .streamed_i(strm), .overwrite_i(ovw),
      .available_o(avail), .pending_o(pend), .checksum_o(csum),
      .overflow_o(ovf), .error_o(errf)
   );

   tart_vis_fetcher #(.CSUM(1)) dut_s (
      .clk_i(clk), .rst_i(rst), .cyc_o(s_cyc), .stb_o(s_stb), .we_o(s_we),
      .ack_i(ack), .wat_i(wat), .rty_i(rty), .err_i(err), .adr_o(s_adr), .sel_o(s_sel),
      .dat_i(dat), .sram_ce_o(s_sce), .sram_we_o(s_swe), .sram_ad_o(s_sad), .sram_be_o(s_sbe),
      .sram_di_o(s_sdi), .switch_i(sw), .streamed_i(strm), .overwrite_i(ovw),
      .available_o(s_avail), .pending_o(s_pend), .checksum_o(s_csum),
      .overflow_o(s_ovf), .error_o(s_errf)
   );

   function automatic logic [9:0] addr_of(int i);
      logic [4:0] b, w;
      b = 5'(i / 24);
      w = 5'(i % 24);
      return {b, w};
   endfunction

   function automatic logic [31:0] dfun(int m, logic [9:0] a);
      case (m)
         0:       return {22'd0, a};
         1:       return 32'd1;
         default: return ({22'd0, a} * 32'h9E3779B1) + 32'h01234567;
      endcase
   endfunction

   function automatic logic [31:0] csx(int m);
      logic [31:0] x = '0;
      for (int i = 0; i < NW; i++) x ^= dfun(m, addr_of(i));
      return x;
   endfunction

   function automatic logic [31:0] css(int m);
      logic [31:0] s = '0;
      for (int i = 0; i < NW; i++) s += dfun(m, addr_of(i));
      return s;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_window(int m, int n);
      for (int i = 0; i < n; i++) q.push_back({addr_of(i), dfun(m, addr_of(i))});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_sw();
      sw = 1'b1;
      tick();
      sw = 1'b0;
   endtask

   task automatic pulse_strm();
      strm = 1'b1;
      tick();
      strm = 1'b0;
   endtask

   task automatic wait_avail(int budget);
      int n = 0;
      while (!avail && n < budget) begin
         tick();
         n++;
      end
      chk("available timeout", {31'd0, avail}, 32'd1);
   endtask

   // Wishbone slave: data follows the address; optional wait/retry injection at one address.
   always @(negedge clk) begin
      dat = dfun(mode, adr);
      ack = 1'b0;
      rty = 1'b0;
      wat = 1'b0;
      if (stb && !rst) begin
         if (inj && adr == inj_adr && wat_done < wat_n) begin
            wat = 1'b1;
            wat_done++;
         end else if (inj && adr == inj_adr && rty_done < rty_n) begin
            rty = 1'b1;
            rty_done++;
         end else begin
            ack = 1'b1;
         end
      end
   end

   // SRAM-write monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && sce) begin
         logic [41:0] e;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL sram write unexpected: got ad=%0h di=%0h expected none", sad, sdi);
         end else begin
            e = q.pop_front();
            if ({swe, sbe, sad, sdi} !== {1'b1, 4'hF, e}) begin
               errors++;
               $display("FAIL sram write: got we=%0b be=%0h ad=%0h di=%0h expected ad=%0h di=%0h",
                        swe, sbe, sad, sdi, e[41:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst cyc", {31'd0, cyc}, 0);
      chk("rst sce", {31'd0, sce}, 0);
      chk("rst avail", {31'd0, avail}, 0);
      rst = 1'b0;
      tick();
      chk("idle pending", {29'd0, pend}, 0);
      chk("idle checksum", csum, 0);
      chk("idle flags", {30'd0, ovf, errf}, 0);

      // 1: zero-wait window, dat = address; latency and checksum
      mode = 0;
      push_window(0, NW);
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("t1 pending after switch", {29'd0, pend}, 1);
      chk("t1 stb before start", {31'd0, stb}, 0);
      tick();
      chk("t1 stb one cycle after start", {31'd0, stb}, 1);
      chk("t1 pending after start", {29'd0, pend}, 0);
      n = 1;
      while (!avail && n < 3000) begin
         tick();
         n++;
      end
      chk("t1 latency to available", n, 1153);
      chk("t1 xor checksum", csum, csx(0));
      chk("t1 sum checksum", s_csum, css(0));
      chk("t1 queue drained", q.size(), 0);
      pulse_strm();
      chk("t1 available after streamed", {31'd0, avail}, 0);

      // 1b: hashed data gives a non-trivial checksum
      mode = 2;
      push_window(2, NW);
      pulse_sw();
      wait_avail(1300);
      chk("t1b xor checksum", csum, csx(2));
      chk("t1b sum checksum", s_csum, css(2));
      pulse_strm();

      // 2: all-ones data, additive checksum counts words
      mode = 1;
      push_window(1, NW);
      pulse_sw();
      wait_avail(1300);
      chk("t2 sum checksum", s_csum, 32'd576);
      chk("t2 xor checksum", csum, 32'd0);
      pulse_strm();
      chk("t2 available", {31'd0, avail}, 0);
      chk("t2 pending", {29'd0, pend}, 0);

      // 4a: word (2,5) waits twice, retries three times, then acks
      mode = 0;
      inj = 1'b1;
      inj_adr = {5'd2, 5'd5};
      rty_n = 3; rty_done = 0;
      wat_n = 2; wat_done = 0;
      push_window(0, NW);
      pulse_sw();
      wait_avail(1300);
      chk("t4 no error after 3 retries", {31'd0, errf}, 0);
      chk("t4 queue drained", q.size(), 0);
      pulse_strm();

      // 4b: four retries abort the window
      rty_n = 4; rty_done = 0;
      wat_n = 0; wat_done = 0;
      push_window(0, 2 * 24 + 5);
      pulse_sw();
      n = 0;
      while (!errf && n < 500) begin
         tick();
         n++;
      end
      chk("t4 error set", {31'd0, errf}, 1);
      chk("t4 cyc idle", {31'd0, cyc}, 0);
      chk("t4 available", {31'd0, avail}, 0);
      chk("t4 partial writes", q.size(), 0);
      inj = 1'b0;

      // 3: window completes, then banks pile up until the counter saturates
      mode = 0;
      push_window(0, NW);
      pulse_sw();
      wait_avail(1300);
      for (int k = 1; k <= 7; k++) begin
         pulse_sw();
         chk("t3 pending count", {29'd0, pend}, k);
      end
      chk("t3 no overflow yet", {31'd0, ovf}, 0);
      pulse_sw();
      chk("t3 pending saturated", {29'd0, pend}, 7);
      chk("t3 overflow", {31'd0, ovf}, 1);
      mode = 2;
      push_window(2, NW);
      strm = 1'b1;
      tick();
      strm = 1'b0;
      sw = 1'b1;
      tick();
      sw = 1'b0;
      chk("t3 switch with start", {29'd0, pend}, 7);
      chk("t3 fetch started", {31'd0, stb}, 1);
      wait_avail(1300);
      chk("t3 xor checksum", csum, csx(2));

      // 5: overwrite restarts from READY immediately
      mode = 0;
      push_window(0, NW);
      ovw = 1'b1;
      tick();
      ovw = 1'b0;
      chk("t5 refetch stb", {31'd0, stb}, 1);
      chk("t5 available dropped", {31'd0, avail}, 0);
      chk("t5 pending", {29'd0, pend}, 6);
      chk("t5 checksum restart", csum, 0);
      chk("t5 sum checksum restart", s_csum, 0);
      wait_avail(1300);
      chk("t5 sum checksum", s_csum, css(0));
      repeat (5) tick();
      chk("t5 holds without overwrite", {31'd0, avail}, 1);
      chk("t5 no fetch", {31'd0, cyc}, 0);
      chk("t5 pending held", {29'd0, pend}, 6);

      // 6: reset mid-transfer, then a clean fetch
      push_window(0, NW);
      pulse_strm();
      repeat (20) tick();
      n = 0;
      while (!sce && n < 10) begin
         tick();
         n++;
      end
      chk("t6 in store", {31'd0, sce}, 1);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("t6 rst cyc/stb", {30'd0, cyc, stb}, 0);
      chk("t6 rst sce", {31'd0, sce}, 0);
      chk("t6 rst pending", {29'd0, pend}, 0);
      chk("t6 rst flags", {29'd0, ovf, errf, avail}, 0);
      tick();
      rst = 1'b0;
      mode = 2;
      push_window(2, NW);
      pulse_sw();
      wait_avail(1300);
      chk("t6 xor checksum", csum, csx(2));
      chk("t6 sum checksum", s_csum, css(2));
      chk("t6 queue drained", q.size(), 0);
      chk("t6 error clear", {31'd0, errf}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
